mem_port_arbiter: RTL and testbench

- Shares one physical memory port between the instruction-fetch requester (port A, read-only) and the data/MEM-stage requester (port B, read/write).
- Sits between the fetch datapath and data stage on one side and the unified memory on the other.
- Presents each side the same read/resp handshake the fetch datapath already uses.
- Data side has priority; a streak limit prevents fetch starvation.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_grant_logic.sv | 37 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef logic [15:0] lc3b_word;

    // Arbiter FSM encoding, kept as plain constants for legacy tools
    typedef logic [1:0] lc3b_arb_state;
    localparam lc3b_arb_state IDLE    = 2'd0;
    localparam lc3b_arb_state SERVE_A = 2'd1;
    localparam lc3b_arb_state SERVE_B = 2'd2;

    localparam int LC3B_ARB_STARVE_DEFAULT = 2;

    // Wide enough for the largest legal starvation limit (7)
    localparam int STREAK_W = 3;
    typedef logic [STREAK_W-1:0] arb_streak_t;

endpackage

// File: rtl/arb_grant_logic.sv
// rtl/arb_grant_logic.sv - combinational priority and fetch-starvation decision
module arb_grant_logic
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = LC3B_ARB_STARVE_DEFAULT
) (
    input  logic          read_a,
    input  logic          req_b,
    input  arb_streak_t   streak,
    output lc3b_arb_state grant,
    output arb_streak_t   streak_next
);

    localparam arb_streak_t LIMIT = arb_streak_t'(STARVE_LIMIT);

    // Data side wins ties until it has won LIMIT times in a row over a waiting fetch
    always_comb begin
        grant       = IDLE;
        streak_next = streak;
        if (read_a && req_b) begin
            if (streak < LIMIT) begin
                grant       = SERVE_B;
                streak_next = streak + 1'b1;
            end else begin
                grant       = SERVE_A;
                streak_next = '0;
            end
        end else if (read_a) begin
            grant       = SERVE_A;
            streak_next = '0;
        end else if (req_b) begin
            grant       = SERVE_B;
            streak_next = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (A) and data (B) requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = LC3B_ARB_STARVE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_a,
    input  lc3b_word    address_a,
    output logic        resp_a,
    output lc3b_word    rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  lc3b_word    address_b,
    input  lc3b_word    wdata_b,
    output logic        resp_b,
    output lc3b_word    rdata_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_wmask,
    output lc3b_word    mem_address,
    output lc3b_word    mem_wdata,
    input  logic        mem_resp,
    input  lc3b_word    mem_rdata
);

    lc3b_arb_state state;
    arb_streak_t   streak;
    logic          orphan;

    lc3b_word      lat_address;
    lc3b_word      lat_wdata;
    logic [1:0]    lat_wmask;
    logic          lat_write;

    logic          req_b;
    lc3b_arb_state grant;
    arb_streak_t   streak_next;
    logic          granted_req;
    logic          deliver;

    assign req_b = read_b | write_b;

    arb_grant_logic #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .read_a      (read_a),
        .req_b       (req_b),
        .streak      (streak),
        .grant       (grant),
        .streak_next (streak_next)
    );

    // Is the owner of the current transaction still asking for it
    always_comb begin
        granted_req = 1'b0;
        case (state)
            SERVE_A: granted_req = read_a;
            SERVE_B: granted_req = req_b;
            default: granted_req = 1'b0;
        endcase
    end

    // Grant from IDLE, latch the winner's request, track aborts until the memory answers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            streak      <= '0;
            orphan      <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_wmask   <= '0;
            lat_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= grant;
                    streak <= streak_next;
                    orphan <= 1'b0;
                    if (grant == SERVE_A) begin
                        lat_address <= address_a;
                        lat_wdata   <= '0;
                        lat_wmask   <= '0;
                        lat_write   <= 1'b0;
                    end else if (grant == SERVE_B) begin
                        lat_address <= address_b;
                        lat_wdata   <= wdata_b;
                        lat_wmask   <= wmask_b;
                        lat_write   <= write_b;
                    end
                end
                SERVE_A, SERVE_B: begin
                    if (mem_resp) begin
                        state  <= IDLE;
                        orphan <= 1'b0;
                    end else if (!granted_req) begin
                        orphan <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes come from the latched request so an abort cannot disturb an in-flight access
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = '0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state)
            SERVE_A: begin
                mem_read    = 1'b1;
                mem_address = lat_address;
            end
            SERVE_B: begin
                mem_address = lat_address;
                mem_wdata   = lat_wdata;
                if (lat_write) begin
                    mem_write = 1'b1;
                    mem_wmask = lat_wmask;
                end else begin
                    mem_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A response is only handed back to a requester that is still waiting for it
    assign deliver = mem_resp && granted_req && !orphan;
    assign resp_a  = (state == SERVE_A) && deliver;
    assign resp_b  = (state == SERVE_B) && deliver;
    assign rdata_a = resp_a ? mem_rdata : '0;
    assign rdata_b = resp_b ? mem_rdata : '0;

    a_rw_conflict: assert property (@(posedge clk) disable iff (!rst_n) !(read_b && write_b))
        else $error("read_b and write_b asserted together; write takes precedence");

    a_idle_resp: assert property (@(posedge clk) disable iff (!rst_n) !((state == IDLE) && mem_resp))
        else $error("mem_resp received with no transaction outstanding");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_a;
    logic [15:0] address_a;
    logic        resp_a;
    logic [15:0] rdata_a;
    logic        read_b;
    logic        write_b;
    logic [1:0]  wmask_b;
    logic [15:0] address_b;
    logic [15:0] wdata_b;
    logic        resp_b;
    logic [15:0] rdata_b;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    // Reference model state: who owns the port (0 none, 1 fetch, 2 data),
    // how many data wins in a row a waiting fetch has suffered, and the granted request
    int          owner;
    int          b_run;
    bit          dropped;
    int          delay;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [1:0]  lat_mask;
    bit          lat_wr;
    bit          a_wants;
    bit          b_wants;
    bit          e_read;
    bit          e_write;
    bit          e_ra;
    bit          e_rb;
    bit          wr;
    int          who;

    logic        n_read_a;
    logic [15:0] n_addr_a;
    logic        n_read_b;
    logic        n_write_b;
    logic [15:0] n_addr_b;
    logic [15:0] n_wdata_b;
    logic [1:0]  n_wmask_b;
    logic        n_mem_resp;
    logic [15:0] n_mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_a      (read_a),
        .address_a   (address_a),
        .resp_a      (resp_a),
        .rdata_a     (rdata_a),
        .read_b      (read_b),
        .write_b     (write_b),
        .wmask_b     (wmask_b),
        .address_b   (address_b),
        .wdata_b     (wdata_b),
        .resp_b      (resp_b),
        .rdata_b     (rdata_b),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wmask   (mem_wmask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outputs_zero(input string tag);
        check_eq({tag, "_mem_read"}, 32'(mem_read), 0);
        check_eq({tag, "_mem_write"}, 32'(mem_write), 0);
        check_eq({tag, "_mem_wmask"}, 32'(mem_wmask), 0);
        check_eq({tag, "_mem_address"}, 32'(mem_address), 0);
        check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check_eq({tag, "_resp_a"}, 32'(resp_a), 0);
        check_eq({tag, "_rdata_a"}, 32'(rdata_a), 0);
        check_eq({tag, "_resp_b"}, 32'(resp_b), 0);
        check_eq({tag, "_rdata_b"}, 32'(rdata_b), 0);
    endtask

    // One cycle with a zero-latency memory: classify the strobe (A at 0x1000, B at 0x2000),
    // answer it immediately and check the answer reaches only the matching requester
    task automatic observe_cycle(output int seen);
        tick();
        seen = 0;
        if (mem_read || mem_write) seen = (mem_address == 16'h2000) ? 2 : 1;
        mem_rdata = 16'($urandom);
        mem_resp  = (seen != 0);
        #1;
        check_eq("obs_resp_a", 32'(resp_a), 32'(seen == 1));
        check_eq("obs_rdata_a", 32'(rdata_a), (seen == 1) ? 32'(mem_rdata) : 32'd0);
        check_eq("obs_resp_b", 32'(resp_b), 32'(seen == 2));
        check_eq("obs_rdata_b", 32'(rdata_b), (seen == 2) ? 32'(mem_rdata) : 32'd0);
    endtask

    // Grant pattern for both sides requesting continuously from a zero streak:
    // odd cycles carry a grant, every (LIMIT+1)-th grant goes to fetch, even cycles are bubbles
    function automatic int expected_grant(input int k);
        if (k % 2 == 0) return 0;
        return (((k - 1) / 2) % (LIMIT + 1) == LIMIT) ? 1 : 2;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        read_a = 1'b0; address_a = '0;
        read_b = 1'b0; write_b = 1'b0; wmask_b = '0; address_b = '0; wdata_b = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        #3;
        outputs_zero("reset");
        #20;
        rst_n = 1'b1;
        tick();

        // Fetch alone: strobe from cycle 1, memory answers in cycle 4
        read_a = 1'b1; address_a = 16'h3000;
        #1;
        check_eq("a_only_c0_read", 32'(mem_read), 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq("a_only_read", 32'(mem_read), 1);
            check_eq("a_only_write", 32'(mem_write), 0);
            check_eq("a_only_addr", 32'(mem_address), 32'h3000);
            if (c == 4) begin
                mem_resp = 1'b1; mem_rdata = 16'h1234;
            end
            #1;
            check_eq("a_only_resp_a", 32'(resp_a), 32'(c == 4));
            check_eq("a_only_rdata_a", 32'(rdata_a), (c == 4) ? 32'h1234 : 32'h0);
            check_eq("a_only_resp_b", 32'(resp_b), 0);
        end
        read_a = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        check_eq("a_only_bubble", 32'(mem_read), 0);

        // Both sides requesting continuously
        read_a = 1'b1; address_a = 16'h1000;
        read_b = 1'b1; address_b = 16'h2000;
        for (int k = 1; k <= 12; k++) begin
            observe_cycle(who);
            check_eq("grant_order", 32'(who), 32'(expected_grant(k)));
        end
        #1;
        read_a = 1'b0; read_b = 1'b0;
        tick();
        mem_resp = 1'b0;

        // Data write
        write_b = 1'b1; address_b = 16'h4002; wdata_b = 16'hBEEF; wmask_b = 2'b10;
        tick();
        check_eq("wr_mem_write", 32'(mem_write), 1);
        check_eq("wr_mem_read", 32'(mem_read), 0);
        check_eq("wr_mem_wmask", 32'(mem_wmask), 32'h2);
        check_eq("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check_eq("wr_mem_addr", 32'(mem_address), 32'h4002);
        mem_resp = 1'b1; mem_rdata = 16'h0;
        #1;
        check_eq("wr_resp_b", 32'(resp_b), 1);
        check_eq("wr_resp_a", 32'(resp_a), 0);
        write_b = 1'b0;
        tick();
        mem_resp = 1'b0;

        // Fetch redirect: abort at 0x3000, re-request at 0x3010 during the orphan
        read_a = 1'b1; address_a = 16'h3000;
        tick();
        check_eq("abort_addr0", 32'(mem_address), 32'h3000);
        read_a = 1'b0;
        tick();
        check_eq("abort_addr1", 32'(mem_address), 32'h3000);
        check_eq("abort_read1", 32'(mem_read), 1);
        read_a = 1'b1; address_a = 16'h3010;
        tick();
        check_eq("abort_addr2", 32'(mem_address), 32'h3000);
        mem_resp = 1'b1; mem_rdata = 16'h7777;
        #1;
        check_eq("abort_resp_a", 32'(resp_a), 0);
        check_eq("abort_rdata_a", 32'(rdata_a), 0);
        tick();
        mem_resp = 1'b0;
        #1;
        check_eq("abort_bubble", 32'(mem_read), 0);
        tick();
        check_eq("abort_retry_read", 32'(mem_read), 1);
        check_eq("abort_retry_addr", 32'(mem_address), 32'h3010);
        mem_resp = 1'b1; mem_rdata = 16'h1111;
        #1;
        check_eq("abort_retry_resp_a", 32'(resp_a), 1);
        check_eq("abort_retry_rdata_a", 32'(rdata_a), 32'h1111);
        read_a = 1'b0;
        tick();
        mem_resp = 1'b0;

        // Asynchronous reset in the middle of a data read, then streak restarts from zero
        read_a = 1'b1; address_a = 16'h1000;
        read_b = 1'b1; address_b = 16'h2000;
        tick();
        check_eq("rst_pre_read", 32'(mem_read), 1);
        check_eq("rst_pre_addr", 32'(mem_address), 32'h2000);
        #2;
        rst_n = 1'b0;
        #1;
        outputs_zero("async_rst");
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            observe_cycle(who);
            check_eq("post_rst_grant", 32'(who), 32'(expected_grant(k)));
        end
        #1;
        read_a = 1'b0; read_b = 1'b0;
        tick();
        mem_resp = 1'b0;

        // Randomized traffic against the transaction-level model
        owner = 0; b_run = 0; dropped = 1'b0; delay = 0;
        lat_addr = '0; lat_wdata = '0; lat_mask = '0; lat_wr = 1'b0;
        n_read_a = 1'b0; n_addr_a = '0;
        n_read_b = 1'b0; n_write_b = 1'b0; n_addr_b = '0; n_wdata_b = '0; n_wmask_b = '0;
        n_mem_resp = 1'b0; n_mem_rdata = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            read_a = n_read_a; address_a = n_addr_a;
            read_b = n_read_b; write_b = n_write_b; address_b = n_addr_b;
            wdata_b = n_wdata_b; wmask_b = n_wmask_b;
            mem_resp = n_mem_resp; mem_rdata = n_mem_rdata;
            #4;

            e_read  = (owner == 1) || (owner == 2 && !lat_wr);
            e_write = (owner == 2) && lat_wr;
            e_ra    = (owner == 1) && mem_resp && !dropped && read_a;
            e_rb    = (owner == 2) && mem_resp && !dropped && (read_b || write_b);
            check_eq("rnd_mem_read", 32'(mem_read), 32'(e_read));
            check_eq("rnd_mem_write", 32'(mem_write), 32'(e_write));
            check_eq("rnd_mem_wmask", 32'(mem_wmask), e_write ? 32'(lat_mask) : 32'd0);
            check_eq("rnd_mem_address", 32'(mem_address), (owner != 0) ? 32'(lat_addr) : 32'd0);
            check_eq("rnd_mem_wdata", 32'(mem_wdata), (owner == 2) ? 32'(lat_wdata) : 32'd0);
            check_eq("rnd_resp_a", 32'(resp_a), 32'(e_ra));
            check_eq("rnd_rdata_a", 32'(rdata_a), e_ra ? 32'(mem_rdata) : 32'd0);
            check_eq("rnd_resp_b", 32'(resp_b), 32'(e_rb));
            check_eq("rnd_rdata_b", 32'(rdata_b), e_rb ? 32'(mem_rdata) : 32'd0);

            if (owner == 0) begin
                a_wants = read_a;
                b_wants = read_b || write_b;
                if (a_wants && b_wants) owner = (b_run < LIMIT) ? 2 : 1;
                else if (a_wants)       owner = 1;
                else if (b_wants)       owner = 2;
                if (owner == 2 && a_wants) b_run = b_run + 1;
                else if (owner != 0)       b_run = 0;
                if (owner == 1) begin
                    lat_addr = address_a; lat_wdata = '0; lat_mask = '0; lat_wr = 1'b0;
                end else if (owner == 2) begin
                    lat_addr = address_b; lat_wdata = wdata_b; lat_mask = wmask_b; lat_wr = write_b;
                end
                dropped = 1'b0;
                delay = $urandom_range(0, 3);
            end else if (mem_resp) begin
                owner = 0;
                dropped = 1'b0;
            end else if (!((owner == 1) ? read_a : (read_b || write_b))) begin
                dropped = 1'b1;
            end

            if (read_a && !e_ra) begin
                if ($urandom_range(0, 15) == 0) n_read_a = 1'b0;
            end else begin
                n_read_a = ($urandom_range(0, 1) == 0);
                if (n_read_a) n_addr_a = 16'($urandom);
            end

            if ((read_b || write_b) && !e_rb) begin
                if ($urandom_range(0, 15) == 0) begin
                    n_read_b = 1'b0; n_write_b = 1'b0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                wr = ($urandom_range(0, 1) == 1);
                n_read_b = !wr; n_write_b = wr;
                n_addr_b = 16'($urandom); n_wdata_b = 16'($urandom); n_wmask_b = 2'($urandom);
            end else begin
                n_read_b = 1'b0; n_write_b = 1'b0;
            end

            n_mem_resp = 1'b0;
            if (owner != 0) begin
                if (delay == 0) n_mem_resp = 1'b1;
                else delay = delay - 1;
            end
            n_mem_rdata = 16'($urandom);

            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
